// File: rtl/shake_rng_feeder_pkg.sv
`default_nettype none
//==============================================================================
// Module      : shake_rng_feeder_pkg
// Description : Shared constants and types for the SHAKE256 squeeze-block
//               feeder and the Gaussian sampler that consumes its samples.
//               - RATE_WORDS_SHAKE256 : 64-bit lanes per squeeze block
//               - LANE_W              : lane width in bits
//               - SAMPLE_W            : width of one rng sample (two lanes)
//               - feeder_state_t      : feeder FSM state encoding
// Revision    : 1.0 - initial release
//==============================================================================
package shake_rng_feeder_pkg;

   localparam int RATE_WORDS_SHAKE256 = 17;
   localparam int LANE_W              = 64;
   localparam int SAMPLE_W            = 128;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH    = 2'd1,
      ST_PRESENT  = 2'd2,
      ST_WAIT_EXT = 2'd3
   } feeder_state_t;

endpackage : shake_rng_feeder_pkg
`default_nettype wire

// File: rtl/shake_rng_feeder.sv
`default_nettype none
//==============================================================================
// Module      : shake_rng_feeder
// Description : Requests squeeze blocks from the Keccak sponge, buffers one
//               block and hands it out as 128-bit samples over the
//               rng/rng_valid/extract interface. With an odd number of lanes
//               per block, the last lane of every other block is carried over
//               and becomes the low half of the first sample of the next one.
// Ports       :
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   level enable; low aborts and clears the buffer
//   sq_req     out  level request for the next squeeze block
//   blk_valid  in   one-cycle strobe qualifying blk
//   blk        in   squeeze block, lane i = blk[64i+63:64i]
//   rng_valid  out  one-cycle strobe, rng holds a new sample
//   rng        out  sample, [63:0] earlier lane, [127:64] next lane
//   extract    in   consumer pop, honoured only while waiting for it
// Revision    : 1.0 - initial release
//==============================================================================
module shake_rng_feeder
   import shake_rng_feeder_pkg::*;
#(
   // Must be odd and >= 3.
   parameter int RATE_WORDS = RATE_WORDS_SHAKE256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   output logic                         sq_req,
   input  logic                         blk_valid,
   input  logic [LANE_W*RATE_WORDS-1:0] blk,
   output logic                         rng_valid,
   output logic [SAMPLE_W-1:0]          rng,
   input  logic                         extract
);

   localparam int BLK_W = LANE_W * RATE_WORDS;
   // ptr must reach RATE_WORDS (all lanes consumed).
   localparam int PTR_W = $clog2(RATE_WORDS + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RATE_WORDS - 1);
   localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(RATE_WORDS);

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   feeder_state_t     state,      state_nx;
   logic [PTR_W-1:0]  ptr,        ptr_nx;
   logic              carry,      carry_nx;
   logic [LANE_W-1:0] carry_lane, carry_lane_nx;
   // The sample on rng was built from the carry lane plus lane 0, so the pop
   // consumes only one lane of the block register.
   logic              use_carry,  use_carry_nx;
   // A squeeze request was abandoned mid-flight; its answer is still owed.
   logic              stale,      stale_nx;
   logic [BLK_W-1:0]  blk_buf,    blk_buf_nx;
   logic [SAMPLE_W-1:0] rng_nx;
   logic              sq_req_nx;
   logic              rng_valid_nx;

   logic [PTR_W-1:0]  ptr_adv;
   logic [PTR_W-1:0]  ptr_adv_hi;

   //---------------------------------------------------------------------------
   // Lane mux indexed by ptr; out-of-range indices return zero.
   //---------------------------------------------------------------------------
   function automatic logic [LANE_W-1:0] lane_of(
      input logic [BLK_W-1:0] b,
      input logic [PTR_W-1:0] idx
   );
      logic [LANE_W-1:0] lane;
      lane = '0;
      for (int i = 0; i < RATE_WORDS; i++) begin
         if (idx == PTR_W'(i)) begin
            lane = b[LANE_W*i +: LANE_W];
         end
      end
      return lane;
   endfunction

   // Pointer after the sample currently on rng is popped.
   assign ptr_adv    = use_carry ? (ptr + PTR_W'(1)) : (ptr + PTR_W'(2));
   assign ptr_adv_hi = ptr_adv + PTR_W'(1);

   //---------------------------------------------------------------------------
   // Next-state and next-output logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_nx      = state;
      ptr_nx        = ptr;
      carry_nx      = carry;
      carry_lane_nx = carry_lane;
      use_carry_nx  = use_carry;
      stale_nx      = stale;
      blk_buf_nx    = blk_buf;
      rng_nx        = rng;

      // The sponge answers every request exactly once, so whichever block
      // arrives next settles an outstanding abandoned request.
      if (blk_valid) begin
         stale_nx = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            if (ena) begin
               state_nx = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (blk_valid && !stale) begin
               blk_buf_nx = blk;
               ptr_nx     = '0;
               if (carry) begin
                  rng_nx       = {lane_of(blk, '0), carry_lane};
                  use_carry_nx = 1'b1;
                  carry_nx     = 1'b0;
               end else begin
                  rng_nx       = {lane_of(blk, PTR_W'(1)), lane_of(blk, '0)};
                  use_carry_nx = 1'b0;
               end
               state_nx = ST_PRESENT;
            end
         end

         ST_PRESENT: begin
            state_nx = ST_WAIT_EXT;
         end

         ST_WAIT_EXT: begin
            if (extract) begin
               ptr_nx       = ptr_adv;
               use_carry_nx = 1'b0;
               if (ptr_adv == PTR_END) begin
                  state_nx = ST_FETCH;
               end else if (ptr_adv == PTR_LAST) begin
                  // Odd lane out: keep it as the low half of the next sample.
                  carry_lane_nx = lane_of(blk_buf, PTR_LAST);
                  carry_nx      = 1'b1;
                  state_nx      = ST_FETCH;
               end else begin
                  rng_nx   = {lane_of(blk_buf, ptr_adv_hi), lane_of(blk_buf, ptr_adv)};
                  state_nx = ST_PRESENT;
               end
            end
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      // Abort overrides everything, including a block arriving this cycle.
      if (!ena) begin
         state_nx      = ST_IDLE;
         ptr_nx        = '0;
         carry_nx      = 1'b0;
         carry_lane_nx = '0;
         use_carry_nx  = 1'b0;
         blk_buf_nx    = '0;
         rng_nx        = '0;
         // A request dropped before its answer leaves that answer in flight.
         if ((state == ST_FETCH) && !blk_valid) begin
            stale_nx = 1'b1;
         end
      end

      // Outputs are registered copies of the state being entered.
      sq_req_nx    = (state_nx == ST_FETCH);
      rng_valid_nx = (state_nx == ST_PRESENT);
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         carry      <= 1'b0;
         carry_lane <= '0;
         use_carry  <= 1'b0;
         stale      <= 1'b0;
         blk_buf    <= '0;
         rng        <= '0;
         sq_req     <= 1'b0;
         rng_valid  <= 1'b0;
      end else begin
         state      <= state_nx;
         ptr        <= ptr_nx;
         carry      <= carry_nx;
         carry_lane <= carry_lane_nx;
         use_carry  <= use_carry_nx;
         stale      <= stale_nx;
         blk_buf    <= blk_buf_nx;
         rng        <= rng_nx;
         sq_req     <= sq_req_nx;
         rng_valid  <= rng_valid_nx;
      end
   end

endmodule : shake_rng_feeder
`default_nettype wire

// File: tb/tb_shake_rng_feeder.sv
`default_nettype none
//==============================================================================
// Module      : tb_shake_rng_feeder
// Description : Self-checking bench for shake_rng_feeder. Expected samples are
//               derived from a lane-stream model fed with every block the
//               bench expects the design to accept.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_shake_rng_feeder;

   localparam int RW = 17;

   logic              clk;
   logic              rst_n;
   logic              ena;
   logic              sq_req;
   logic              blk_valid;
   logic [64*RW-1:0]  blk;
   logic              rng_valid;
   logic [127:0]      rng;
   logic              extract;

   shake_rng_feeder #(.RATE_WORDS(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .sq_req    (sq_req),
      .blk_valid (blk_valid),
      .blk       (blk),
      .rng_valid (rng_valid),
      .rng       (rng),
      .extract   (extract)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0]  lanes[$];
   logic [127:0] exp_q[$];
   logic [127:0] seen[$];
   logic [127:0] last_exp = '0;
   logic [127:0] mon_e;
   logic         prev_rv = 1'b0;

   typedef struct {
      bit ena;
      bit bv;
      int id;
      bit push;
      bit ex;
      bit exp_sq;
      bit exp_rv;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [64*RW-1:0] mk_blk(input int id);
      logic [64*RW-1:0] b;
      for (int i = 0; i < RW; i++) b[64*i +: 64] = {32'(id), 32'(i)};
      return b;
   endfunction

   task automatic model_clear();
      lanes.delete();
      exp_q.delete();
   endtask

   task automatic model_push(input int id);
      logic [63:0] lo, hi;
      for (int i = 0; i < RW; i++) lanes.push_back({32'(id), 32'(i)});
      while (lanes.size() >= 2) begin
         lo = lanes.pop_front();
         hi = lanes.pop_front();
         exp_q.push_back({hi, lo});
      end
   endtask

   // Drive one cycle of inputs; returns 2 time units after the clock edge.
   task automatic step(input bit e, input bit bv, input int id, input bit push, input bit ex);
      if (!e) model_clear();
      if (bv && push) model_push(id);
      ena       = e;
      blk_valid = bv;
      blk       = bv ? mk_blk(id) : '0;
      extract   = ex;
      @(posedge clk);
      #2;
      blk_valid = 1'b0;
      extract   = 1'b0;
   endtask

   // Sample monitor: scoreboard comparison and single-pulse check.
   always @(posedge clk) begin
      #1;
      if (rng_valid) begin
         chk("rng_valid_single_pulse", 128'(prev_rv), 128'(0));
         seen.push_back(rng);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sample_unexpected: got %h required no sample", rng);
         end else begin
            mon_e    = exp_q.pop_front();
            last_exp = mon_e;
            chk("sample", rng, mon_e);
         end
      end
      prev_rv = rng_valid;
   end

   initial begin
      rst_n     = 1'b0;
      ena       = 1'b0;
      blk_valid = 1'b0;
      blk       = '0;
      extract   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      chk("reset_sq_req", 128'(sq_req), 128'(0));
      chk("reset_rng_valid", 128'(rng_valid), 128'(0));
      chk("reset_rng", rng, 128'(0));
      rst_n = 1'b1;

      // Start-up, first sample, extract ignored in PRESENT, blk ignored off FETCH
      vecs[0] = '{ena:0, bv:0, id:0, push:0, ex:0, exp_sq:0, exp_rv:0};
      vecs[1] = '{ena:1, bv:0, id:0, push:0, ex:0, exp_sq:1, exp_rv:0};
      vecs[2] = '{ena:1, bv:0, id:0, push:0, ex:0, exp_sq:1, exp_rv:0};
      vecs[3] = '{ena:1, bv:1, id:0, push:1, ex:0, exp_sq:0, exp_rv:1};
      vecs[4] = '{ena:1, bv:0, id:0, push:0, ex:1, exp_sq:0, exp_rv:0};
      vecs[5] = '{ena:1, bv:0, id:0, push:0, ex:0, exp_sq:0, exp_rv:0};
      vecs[6] = '{ena:1, bv:0, id:0, push:0, ex:1, exp_sq:0, exp_rv:1};
      vecs[7] = '{ena:1, bv:1, id:1, push:0, ex:0, exp_sq:0, exp_rv:0};
      vecs[8] = '{ena:1, bv:0, id:0, push:0, ex:1, exp_sq:0, exp_rv:1};
      for (int v = 0; v < 9; v++) begin
         step(vecs[v].ena, vecs[v].bv, vecs[v].id, vecs[v].push, vecs[v].ex);
         chk($sformatf("vec%0d_sq_req", v), 128'(sq_req), 128'(vecs[v].exp_sq));
         chk($sformatf("vec%0d_rng_valid", v), 128'(rng_valid), 128'(vecs[v].exp_rv));
      end

      // Rest of block 0: samples 3..7
      for (int k = 3; k < 8; k++) begin
         step(1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 1);
         chk($sformatf("blk0_s%0d_rng_valid", k), 128'(rng_valid), 128'(1));
      end
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      chk("blk0_end_sq_req", 128'(sq_req), 128'(1));
      chk("blk0_end_rng_valid", 128'(rng_valid), 128'(0));

      // Block 1: carry-spanning sample 8, then 9..16
      step(1, 1, 1, 1, 0);
      chk("blk1_s8_rng_valid", 128'(rng_valid), 128'(1));
      chk("blk1_s8_sq_req", 128'(sq_req), 128'(0));
      for (int k = 9; k < 17; k++) begin
         step(1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 1);
         chk($sformatf("blk1_s%0d_rng_valid", k), 128'(rng_valid), 128'(1));
      end
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      chk("blk1_end_sq_req", 128'(sq_req), 128'(1));

      // Block 4 without carry, then a consumer that delays extract
      step(1, 1, 4, 1, 0);
      chk("blk4_rng_valid", 128'(rng_valid), 128'(1));
      step(1, 0, 0, 0, 0);
      for (int d = 0; d < 4; d++) begin
         step(1, 0, 0, 0, 0);
         chk($sformatf("delay%0d_rng_valid", d), 128'(rng_valid), 128'(0));
         chk($sformatf("delay%0d_rng_held", d), rng, last_exp);
      end
      step(1, 0, 0, 0, 1);
      chk("delay_next_rng_valid", 128'(rng_valid), 128'(1));
      chk("samples_seen_count", 128'(seen.size()), 128'(19));

      // Abort in WAIT_EXT
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("abort_wait_sq_req", 128'(sq_req), 128'(0));
      chk("abort_wait_rng_valid", 128'(rng_valid), 128'(0));
      chk("abort_wait_rng", rng, 128'(0));
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("restart_sq_req", 128'(sq_req), 128'(1));
      step(1, 1, 5, 1, 0);
      chk("restart_rng_valid", 128'(rng_valid), 128'(1));

      // Abort in FETCH: next block (A) is dropped, B is used
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("stale_refetch_sq_req", 128'(sq_req), 128'(1));
      step(1, 1, 6, 0, 0);
      chk("stale_drop_rng_valid", 128'(rng_valid), 128'(0));
      chk("stale_drop_sq_req", 128'(sq_req), 128'(1));
      step(1, 1, 7, 1, 0);
      chk("stale_b_rng_valid", 128'(rng_valid), 128'(1));
      chk("stale_b_rng", rng, {64'h0000_0007_0000_0001, 64'h0000_0007_0000_0000});

      // Abort coinciding with blk_valid: block discarded, no stale
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 8, 0, 0);
      chk("abort_blk_sq_req", 128'(sq_req), 128'(0));
      chk("abort_blk_rng_valid", 128'(rng_valid), 128'(0));
      step(1, 0, 0, 0, 0);
      chk("abort_blk_refetch_sq_req", 128'(sq_req), 128'(1));
      step(1, 1, 9, 1, 0);
      chk("abort_blk_no_stale_rng_valid", 128'(rng_valid), 128'(1));

      // Asynchronous reset while in PRESENT
      #1;
      rst_n = 1'b0;
      ena   = 1'b0;
      #1;
      chk("async_rst_rng_valid", 128'(rng_valid), 128'(0));
      chk("async_rst_rng", rng, 128'(0));
      chk("async_rst_sq_req", 128'(sq_req), 128'(0));
      model_clear();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(0, 1, 10, 0, 0);
      chk("idle_blk_sq_req", 128'(sq_req), 128'(0));
      chk("idle_blk_rng_valid", 128'(rng_valid), 128'(0));
      step(1, 0, 0, 0, 0);
      chk("post_rst_sq_req", 128'(sq_req), 128'(1));
      step(1, 1, 11, 1, 0);
      chk("post_rst_rng_valid", 128'(rng_valid), 128'(1));
      step(1, 0, 0, 0, 0);

      // Known sample values from the first two blocks
      if (seen.size() >= 17) begin
         chk("sample0", seen[0], {64'h1, 64'h0});
         chk("sample7", seen[7], {64'hF, 64'hE});
         chk("sample8", seen[8], {64'h0000_0001_0000_0000, 64'h10});
         chk("sample16", seen[16], {64'h0000_0001_0000_0010, 64'h0000_0001_0000_000F});
      end else begin
         checks++;
         errors++;
         $display("FAIL sample_history: got %0d samples required at least 17", seen.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_shake_rng_feeder
`default_nettype wire
